// File: rtl/exu_mem_req.sv
// Execute-stage memory request unit: accepts one operation per handshake, issues AXI AR
// or independent AW/W, flags misaligned accesses and hands completions downstream.
module exu_mem_req #(
    parameter  int ADDR_W = 32,
    parameter  int DATA_W = 32,
    parameter  int TAG_W  = 64,
    localparam int OFF_W  = $clog2(DATA_W/8),
    localparam int STRB_W = DATA_W/8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [DATA_W-1:0] in_wdata_i,
    input  logic [1:0]        in_size_i,
    input  logic              in_re_i,
    input  logic              in_we_i,
    input  logic [TAG_W-1:0]  in_tag_i,
    output logic              arvalid_o,
    input  logic              arready_i,
    output logic [ADDR_W-1:0] araddr_o,
    output logic [2:0]        arsize_o,
    output logic              awvalid_o,
    input  logic              awready_i,
    output logic [ADDR_W-1:0] awaddr_o,
    output logic              wvalid_o,
    input  logic              wready_i,
    output logic [DATA_W-1:0] wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic [OFF_W-1:0]  out_offset_o,
    output logic              out_is_load_o,
    output logic              out_misalign_o,
    output logic [31:0]       stall_cnt_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        WR   = 2'd2,
        OUT  = 2'd3
    } state_e;

    // Contiguous strobe of 2^size lanes starting at the byte offset.
    function automatic logic [STRB_W-1:0] strobe_f(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [15:0] mask;
        logic [15:0] shifted;
        mask    = (16'd1 << (16'd1 << size)) - 16'd1;
        shifted = mask << off;
        return shifted[STRB_W-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] replicate_f(input logic [DATA_W-1:0] d, input logic [1:0] size);
        case (size)
            2'd0:    return {(DATA_W/8){d[7:0]}};
            2'd1:    return {(DATA_W/16){d[15:0]}};
            2'd2:    return {(DATA_W/32){d[31:0]}};
            default: return d;
        endcase
    endfunction

    // Dword accesses do not exist on a 32-bit bus, so they are treated as misaligned.
    function automatic logic misalign_f(input logic [2:0] low, input logic [1:0] size);
        logic [3:0] mask;
        mask = (4'd1 << size) - 4'd1;
        return ((({1'b0, low}) & mask) != 4'd0) || ((size == 2'd3) && (DATA_W < 64));
    endfunction

    state_e              state_q, state_d, new_state_s;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]   wstrb_q, wstrb_d;
    logic [1:0]          size_q, size_d;
    logic [TAG_W-1:0]    tag_q, tag_d;
    logic                is_load_q, is_load_d;
    logic                misalign_q, misalign_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic [31:0]         stall_cnt_q, stall_cnt_d;
    logic                in_ready_s, accept_s, new_mis_s, stall_s, load_s;
    logic                aw_hs_s, w_hs_s;

    assign in_ready_s = !reset && ((state_q == IDLE) || ((state_q == OUT) && out_ready_i));
    assign accept_s   = in_valid_i && in_ready_s;
    assign new_mis_s  = misalign_f(in_addr_i[2:0], in_size_i);
    assign aw_hs_s    = awvalid_o && awready_i;
    assign w_hs_s     = wvalid_o && wready_i;

    // Next-state, capture and stall-count logic.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        size_d      = size_q;
        tag_d       = tag_q;
        is_load_d   = is_load_q;
        misalign_d  = misalign_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        stall_cnt_d = stall_cnt_q;
        stall_s     = 1'b0;
        load_s      = 1'b0;

        if (new_mis_s) begin
            new_state_s = OUT;
        end else if (in_we_i) begin
            new_state_s = WR;
        end else if (in_re_i) begin
            new_state_s = AR;
        end else begin
            new_state_s = OUT;
        end

        case (state_q)
            IDLE: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            AR: begin
                if (arready_i) begin
                    state_d = OUT;
                end else begin
                    stall_s = 1'b1;
                end
            end
            WR: begin
                aw_done_d = aw_done_q || aw_hs_s;
                w_done_d  = w_done_q || w_hs_s;
                stall_s   = !(aw_hs_s || w_hs_s);
                if (aw_done_d && w_done_d) begin
                    state_d = OUT;
                end else begin
                    state_d = WR;
                end
            end
            OUT: begin
                if (accept_s) begin
                    load_s = 1'b1;
                end else if (out_ready_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = OUT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (load_s) begin
            state_d    = new_state_s;
            addr_d     = in_addr_i;
            wdata_d    = replicate_f(in_wdata_i, in_size_i);
            wstrb_d    = strobe_f(in_size_i, in_addr_i[OFF_W-1:0]);
            size_d     = in_size_i;
            tag_d      = in_tag_i;
            misalign_d = new_mis_s;
            is_load_d  = !new_mis_s && !in_we_i && in_re_i;
            aw_done_d  = 1'b0;
            w_done_d   = 1'b0;
        end else begin
            addr_d = addr_q;
        end

        if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State and payload registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            size_q      <= 2'd0;
            tag_q       <= '0;
            is_load_q   <= 1'b0;
            misalign_q  <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            size_q      <= size_d;
            tag_q       <= tag_d;
            is_load_q   <= is_load_d;
            misalign_q  <= misalign_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign in_ready_o     = in_ready_s;
    assign arvalid_o      = (state_q == AR);
    assign araddr_o       = addr_q;
    assign arsize_o       = {1'b0, size_q};
    assign awvalid_o      = (state_q == WR) && !aw_done_q;
    assign awaddr_o       = addr_q;
    assign wvalid_o       = (state_q == WR) && !w_done_q;
    assign wdata_o        = wdata_q;
    assign wstrb_o        = wstrb_q;
    assign out_valid_o    = (state_q == OUT);
    assign out_tag_o      = tag_q;
    assign out_offset_o   = addr_q[OFF_W-1:0];
    assign out_is_load_o  = is_load_q;
    assign out_misalign_o = misalign_q;
    assign stall_cnt_o    = stall_cnt_q;

endmodule

// File: doc/exu_mem_req.md
Name: exu_mem_req

Overview:
Parametrised execute-stage memory request unit, next generation of the single-slot execute/AXI issue logic. It sits between decode/execute and the load-store unit. It accepts one operation per handshake and generates AXI AR, or independent AW/W requests, with size-generic strobes and lane replication. Misaligned accesses are flagged instead of issued, and completed operations are handed downstream with full valid/ready backpressure.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data bus width; 32 or 64
TAG_W, 64, opaque pipeline payload width (rd, flags, result), passed through unchanged
OFF_W, $clog2(DATA_W/8), byte-lane offset width (derived, not overridable)

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid_i  in  1  upstream operation valid
in_ready_o  out  1  unit can accept an operation
in_addr_i  in  ADDR_W  effective address (ALU result)
in_wdata_i  in  DATA_W  store data, right-aligned
in_size_i  in  2  0=byte 1=half 2=word 3=dword
in_re_i  in  1  load
in_we_i  in  1  store
in_tag_i  in  TAG_W  pipeline payload
arvalid_o / arready_i  out/in  1  AXI read address handshake
araddr_o  out  ADDR_W  read address (unaligned address as given)
arsize_o  out  3  {1'b0,size}
awvalid_o / awready_i  out/in  1  AXI write address handshake
awaddr_o  out  ADDR_W  write address
wvalid_o / wready_i  out/in  1  AXI write data handshake
wdata_o  out  DATA_W  lane-replicated store data
wstrb_o  out  DATA_W/8  byte strobes
out_valid_o / out_ready_i  out/in  1  downstream handshake
out_tag_o  out  TAG_W  registered payload
out_offset_o  out  OFF_W  in_addr_i[OFF_W-1:0] for load extraction
out_is_load_o  out  1  read request was issued
out_misalign_o  out  1  access suppressed: misaligned or illegal size
stall_cnt_o  out  32  cycles spent waiting on AXI handshakes

Behaviour:
- Reset: state IDLE, all valid outputs 0, stall_cnt_o 0, in_ready_o 0 during reset, 1 the first cycle after. Reset mid-operation drops the entry; no completion is produced.
- FSM states: IDLE, AR, WR, OUT. Accept = in_valid_i && in_ready_o; all inputs are registered on accept.
- in_ready_o = (state==IDLE) || (state==OUT && out_ready_i). Back-to-back accept on the OUT drain cycle is allowed.
- On accept:
  - Misaligned (address low bits not multiple of 2^size), or size 3 with DATA_W=32: go to OUT with misalign=1. No AXI valid is raised.
  - in_we_i: go to WR; in_we_i takes priority, in_re_i is ignored if both are set.
  - in_re_i: go to AR.
  - Neither: go to OUT. Latency 1 cycle for non-memory ops.
- AR: arvalid_o=1 with stable address/size until arready_i. Handshake cycle moves to OUT next.
- WR:
  - awvalid_o and wvalid_o are both raised the cycle after accept.
  - Each is dropped independently after its own handshake, tracked by aw_done and w_done.
  - Move to OUT when both are done, including the same-cycle case.
  - Either order is legal; an ordering with W before AW must not hang.
- wstrb_o = ((1<<(1<<size))-1) << offset.
- wdata_o = low 2^size bytes of in_wdata_i replicated across all lanes. Dword on DATA_W=64 passes through unchanged.
- OUT: out_valid_o=1, payload stable until out_ready_i. If a new accept happens on the same cycle, go to that op's next state; else go to IDLE.
- stall_cnt_o increments in AR/WR on cycles where no pending handshake completes. It saturates at 0xFFFFFFFF.
- AXI outputs never change while their valid is high and ready is low.

Test Plan:
- DATA_W=32, sb addr 0x8000_0003, wdata 0x0000_00AB, awready/wready=1 -> wstrb=4'b1000, wdata=0xABAB_ABAB, out_valid 2 cycles after accept, misalign=0.
- lw addr 0x8000_0004, arready held 0 for 3 cycles -> arvalid stable for 4 cycles, arsize=3'b010, then out_valid with out_is_load=1, offset=0, stall_cnt=3.
- sh addr 0x1001, or DATA_W=32 with size=3 -> no AR/AW/W ever asserted; out_valid next cycle with misalign=1.
- sw with wready on cycle 1 and awready on cycle 4 -> wvalid drops after cycle 1, awvalid held to cycle 4, exactly one completion.
- 4 non-memory ops, out_ready_i=1 every cycle -> in_ready stays 1, one out_valid per cycle, tags in order. With out_ready_i=0 for 2 cycles -> in_ready=0 and tag held.
- Reset asserted while in WR with awvalid high -> next cycle all valids 0, stall_cnt 0, no out_valid.
